// File: rtl/data_mem_responder_if.sv
// Load/store bus between a core (master) and data_mem_responder (slave).
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with configurable wait states.
// Optional address/alignment checking is enabled by defining DMEM_RANGE_CHECK_EN.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  io_bus
);
    localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic                  r_we;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [Depth];

    logic                  w_accept;
    logic                  w_enter_resp;
    logic                  w_acc_we;
    logic [31:0]           w_acc_addr;
    logic [31:0]           w_acc_wdata;
    logic [3:0]            w_acc_be;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_err;
    logic                  w_mem_we;

    assign w_accept = (r_state == StIdle) && io_bus.req_valid;

    // With zero wait states the access commits on the acceptance edge, before fields are latched.
    assign w_acc_we    = (r_state == StIdle) ? io_bus.req_we    : r_we;
    assign w_acc_addr  = (r_state == StIdle) ? io_bus.req_addr  : r_addr;
    assign w_acc_wdata = (r_state == StIdle) ? io_bus.req_wdata : r_wdata;
    assign w_acc_be    = (r_state == StIdle) ? io_bus.req_be    : r_be;
    assign w_idx       = w_acc_addr[ADDR_WIDTH+1:2];

`ifdef DMEM_RANGE_CHECK_EN
    assign w_err = ((w_acc_addr[1:0] != 2'b00) && (w_acc_be == 4'hF)) ||
                   ((w_acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
`else
    logic w_unused_addr;
    assign w_err         = 1'b0;
    assign w_unused_addr = ^w_acc_addr;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_enter_resp = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (io_bus.req_valid) begin
                    if (WAIT_STATES == 0) begin
                        w_state_next = StResp;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_next = StWait;
                        w_cnt_next   = WaitLoad;
                    end
                end
            end
            StWait: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = StResp;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            StResp: begin
                if (io_bus.rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= io_bus.req_we;
                r_addr  <= io_bus.req_addr;
                r_wdata <= io_bus.req_wdata;
                r_be    <= io_bus.req_be;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_acc_we || w_err) ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    // Memory has no reset; a reset on the commit edge drops the pending store.
    assign w_mem_we = rst && w_enter_resp && w_acc_we && !w_err;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign io_bus.req_ready = (r_state == StIdle);
    assign io_bus.rsp_valid = (r_state == StResp);
    assign io_bus.rsp_rdata = r_rdata;
    assign io_bus.rsp_err   = r_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench: one responder with one wait state, one with none.
module tb_data_mem_responder;
    localparam int unsigned AddrWidth = 10;
    localparam int unsigned Words     = 2 ** AddrWidth;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference memory per DUT plus a per-byte "has been written" mask.
    logic [31:0] m_mem [2][Words];
    logic [3:0]  m_kb  [2][Words];

    always #5 clk = ~clk;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();

    data_mem_responder #(
        .ADDR_WIDTH  (AddrWidth),
        .WAIT_STATES (1)
    ) dut_ws1 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus0)
    );

    data_mem_responder #(
        .ADDR_WIDTH  (AddrWidth),
        .WAIT_STATES (0)
    ) dut_ws0 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input int sel, input logic v, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        if (sel == 0) begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = addr;
            bus0.req_wdata = wdata; bus0.req_be = be;
        end else begin
            bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = addr;
            bus1.req_wdata = wdata; bus1.req_be = be;
        end
    endtask

    task automatic set_rr(input int sel, input logic rr);
        if (sel == 0) bus0.rsp_ready = rr;
        else          bus1.rsp_ready = rr;
    endtask

    task automatic sample(input int sel, output logic rdy, output logic v, output logic [31:0] rd,
                          output logic e);
        if (sel == 0) begin
            rdy = bus0.req_ready; v = bus0.rsp_valid; rd = bus0.rsp_rdata; e = bus0.rsp_err;
        end else begin
            rdy = bus1.req_ready; v = bus1.rsp_valid; rd = bus1.rsp_rdata; e = bus1.rsp_err;
        end
    endtask

    // Applies one access to the reference memory and returns the expected response.
    task automatic model_access(input int sel, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output logic [31:0] exp_rd, output logic exp_e,
                                output logic [31:0] mask);
        int unsigned idx;
        idx = (addr / 4) % Words;
`ifdef DMEM_RANGE_CHECK_EN
        exp_e = ((addr % 4) != 0 && be == 4'hF) || (addr >= 4 * Words);
`else
        exp_e = 1'b0;
`endif
        exp_rd = 32'd0;
        mask   = 32'hFFFF_FFFF;
        if (we) begin
            if (!exp_e) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        m_mem[sel][idx][8*i +: 8] = wdata[8*i +: 8];
                        m_kb[sel][idx][i]         = 1'b1;
                    end
                end
            end
        end else if (!exp_e) begin
            exp_rd = m_mem[sel][idx];
            for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{m_kb[sel][idx][i]}};
        end
    endtask

    task automatic access(input int sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold);
        logic        rdy, v, e, exp_e;
        logic [31:0] rd, rd0, exp_rd, mask;
        int          lat;
        model_access(sel, we, addr, wdata, be, exp_rd, exp_e, mask);
        drive_req(sel, 1'b1, we, addr, wdata, be);
        set_rr(sel, hold == 0);
        sample(sel, rdy, v, rd, e);
        check_eq("req_ready_idle", 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
        drive_req(sel, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
        lat = 0;
        v   = 1'b0;
        while (!v && lat < 40) begin
            @(negedge clk);
            lat++;
            sample(sel, rdy, v, rd, e);
        end
        check_eq("rsp_latency", lat, (sel == 0) ? 32'd2 : 32'd1);
        check_eq("rsp_rdata", rd & mask, exp_rd & mask);
        check_eq("rsp_err", 32'(e), 32'(exp_e));
        check_eq("req_ready_busy", 32'(rdy), 32'd0);
        rd0 = rd;
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            sample(sel, rdy, v, rd, e);
            check_eq("hold_valid", 32'(v), 32'd1);
            check_eq("hold_rdata", rd, rd0);
            check_eq("hold_ready", 32'(rdy), 32'd0);
        end
        set_rr(sel, 1'b1);
        @(negedge clk);
        sample(sel, rdy, v, rd, e);
        check_eq("post_valid", 32'(v), 32'd0);
        check_eq("post_ready", 32'(rdy), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rdy, v, e, de;
        logic [31:0] rd, drd, dmask;
        int          accepts;

        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < Words; w++) begin
                m_kb[s][w]  = 4'd0;
                m_mem[s][w] = 32'd0;
            end
        end

        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            drive_req(s, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
            set_rr(s, 1'b1);
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sample(s, rdy, v, rd, e);
            check_eq("reset_valid", 32'(v), 32'd0);
            check_eq("reset_rdata", rd, 32'd0);
            check_eq("reset_err", 32'(e), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sample(s, rdy, v, rd, e);
            check_eq("reset_ready", 32'(rdy), 32'd1);
        end

        // Basic store/load, byte lanes, backpressure.
        access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        access(0, 1'b0, 32'h10, 32'd0, 4'hF, 0);
        access(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0);
        access(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0);
        access(0, 1'b0, 32'h20, 32'd0, 4'd0, 0);
        access(0, 1'b1, 32'h24, 32'hFFFF_FFFF, 4'd0, 0);
        access(0, 1'b1, 32'h40, 32'h55AA_33CC, 4'hF, 0);
        access(0, 1'b0, 32'h40, 32'd0, 4'd0, 5);

        // Zero wait states: latency and continuous-request throughput.
        access(1, 1'b1, 32'h8, 32'h0102_0304, 4'hF, 0);
        access(1, 1'b0, 32'h8, 32'd0, 4'hF, 0);
        drive_req(1, 1'b1, 1'b0, 32'h8, 32'd0, 4'hF);
        set_rr(1, 1'b1);
        accepts = 0;
        for (int i = 0; i < 10; i++) begin
            sample(1, rdy, v, rd, e);
            if (rdy) accepts++;
            check_eq("no_overlap", 32'(rdy && v), 32'd0);
            @(negedge clk);
        end
        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        check_eq("ws0_accepts", accepts, 32'd5);
        @(negedge clk);

        // Reset during WAIT drops the store.
        access(0, 1'b1, 32'h30, 32'd0, 4'hF, 0);
        drive_req(0, 1'b1, 1'b1, 32'h30, 32'h1234_5678, 4'hF);
        set_rr(0, 1'b1);
        @(posedge clk);
        #1;
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        sample(0, rdy, v, rd, e);
        check_eq("wait_busy", 32'({rdy, v}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sample(0, rdy, v, rd, e);
        check_eq("rst_wait_valid", 32'(v), 32'd0);
        check_eq("rst_wait_ready", 32'(rdy), 32'd1);
        access(0, 1'b0, 32'h30, 32'd0, 4'hF, 0);

        // Reset during RESP keeps the committed store.
        drive_req(0, 1'b1, 1'b1, 32'h34, 32'h0BAD_CAFE, 4'hF);
        set_rr(0, 1'b0);
        @(posedge clk);
        #1;
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (2) @(negedge clk);
        sample(0, rdy, v, rd, e);
        check_eq("resp_before_rst", 32'(v), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        set_rr(0, 1'b1);
        @(negedge clk);
        sample(0, rdy, v, rd, e);
        check_eq("rst_resp_ready", 32'(rdy), 32'd1);
        model_access(0, 1'b1, 32'h34, 32'h0BAD_CAFE, 4'hF, drd, de, dmask);
        access(0, 1'b0, 32'h34, 32'd0, 4'hF, 0);

        // Out-of-range / misaligned store, then the aliased word 0.
        access(0, 1'b1, 32'h0, 32'h7777_8888, 4'hF, 0);
        access(0, 1'b1, 32'h1002, 32'hCAFE_F00D, 4'hF, 0);
        access(0, 1'b0, 32'h0, 32'd0, 4'hF, 0);
        access(0, 1'b0, 32'h1002, 32'd0, 4'h3, 0);

        // Randomized mix over a small hot region with occasional wide addresses.
        for (int n = 0; n < 200; n++) begin
            int unsigned r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r < 8) a = $urandom_range(0, 63) * 4 + ((r == 0) ? $urandom_range(0, 3) : 0);
            else       a = $urandom;
            access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                   4'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
